// File: rtl/pio_input_conditioner.sv
// Board-pin front end for the PIO inports: synchronizes and debounces keys and switches,
// latches sticky key-press flags with host acknowledge, and counts press events.
module pio_input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 18,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic [31:0]       ack_word,
    output logic [31:0]       button_word,
    output logic [31:0]       switch_word,
    output logic              event_pending
);

    localparam int W  = N_KEYS + N_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] key_in;
    logic [W-1:0]      sync_q [SYNC_STAGES];
    logic [W-1:0]      synced;

    logic [W-1:0]      stable_q, stable_d;
    logic [W-1:0]      pending_q, pending_d;
    logic [CW-1:0]     cnt_q [W];
    logic [CW-1:0]     cnt_d [W];

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] ack_prev_q, ack_rise;
    logic [N_KEYS-1:0] sticky_q, sticky_d;
    logic [7:0]        count_q, count_d;

    // Keys are made active-high before the synchronizer so everything downstream is uniform.
    assign key_in = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {sw_raw, key_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            stable_d[i]  = stable_q[i];
            pending_d[i] = pending_q[i];
            cnt_d[i]     = cnt_q[i];
            if (!pending_q[i]) begin
                cnt_d[i] = '0;
                if (synced[i] != stable_q[i]) begin
                    pending_d[i] = 1'b1;
                    cnt_d[i]     = CW'(1);
                end
            end else if (synced[i] == stable_q[i]) begin
                pending_d[i] = 1'b0;
                cnt_d[i]     = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i]  = ~stable_q[i];
                pending_d[i] = 1'b0;
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Events come from the next stable state so flags and count land with the level.
    assign press    = stable_d[N_KEYS-1:0] & ~stable_q[N_KEYS-1:0];
    assign ack_rise = ack_word[N_KEYS-1:0] & ~ack_prev_q;
    assign sticky_d = (sticky_q & ~ack_rise) | press;
    assign count_d  = count_q + {7'd0, |press};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q   <= '0;
            pending_q  <= '0;
            for (int i = 0; i < W; i++) cnt_q[i] <= '0;
            ack_prev_q <= '0;
            sticky_q   <= '0;
            count_q    <= '0;
        end else begin
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
            ack_prev_q <= ack_word[N_KEYS-1:0];
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    logic unused_ack;
    assign unused_ack = ^ack_word[31:N_KEYS];

    always_comb begin
        button_word                = '0;
        button_word[N_KEYS-1:0]    = stable_q[N_KEYS-1:0];
        button_word[16 +: N_KEYS]  = sticky_q;
        button_word[31:24]         = count_q;
        switch_word                = '0;
        switch_word[N_SW-1:0]      = stable_q[W-1:N_KEYS];
    end

    assign event_pending = |sticky_q;

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench for pio_input_conditioner with an 8-cycle debounce window.
module tb_pio_input_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_raw;
    logic [17:0] sw_raw;
    logic [31:0] ack_word;
    logic [31:0] button_word;
    logic [31:0] switch_word;
    logic        event_pending;

    int tests_run = 0;
    int tests_failed = 0;

    pio_input_conditioner #(
        .N_KEYS(4), .N_SW(18), .KEY_ACTIVE_LOW(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw), .ack_word(ack_word),
        .button_word(button_word), .switch_word(switch_word), .event_pending(event_pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_raw = 4'hF; sw_raw = '0; ack_word = '0;
        tick(20);
        tests_run++;
        if (button_word !== 32'h0 || switch_word !== 32'h0 || event_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held: bw=%h sw=%h ep=%b expected 0/0/0", button_word, switch_word, event_pending);
        end
        reset = 1'b0;
        tick(20);
        tests_run++;
        if (button_word !== 32'h0 || switch_word !== 32'h0 || event_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: bw=%h sw=%h ep=%b expected 0/0/0", button_word, switch_word, event_pending);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_press();
        key_raw = 4'hE;
        tick(9);
        tests_run++;
        if (button_word !== 32'h0) begin
            tests_failed++;
            $display("FAIL press_early: bw=%h expected %h", button_word, 32'h0);
        end
        tick(2);
        tests_run++;
        if (button_word !== 32'h0101_0001 || event_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL press_key0: bw=%h ep=%b expected %h/1", button_word, event_pending, 32'h0101_0001);
        end
        $display("[TB] press key0 bw=%h", button_word);
    endtask

    task automatic test_glitch();
        key_raw = 4'hC;
        tick(5);
        key_raw = 4'hE;
        tick(20);
        tests_run++;
        if (button_word !== 32'h0101_0001) begin
            tests_failed++;
            $display("FAIL glitch_key1: bw=%h expected %h", button_word, 32'h0101_0001);
        end
        $display("[TB] glitch key1 bw=%h", button_word);
    endtask

    task automatic test_ack();
        ack_word = 32'h1;
        tick(1);
        tests_run++;
        if (button_word !== 32'h0100_0001) begin
            tests_failed++;
            $display("FAIL ack_clear: bw=%h expected %h", button_word, 32'h0100_0001);
        end
        tick(5);
        tests_run++;
        if (button_word !== 32'h0100_0001 || event_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_hold: bw=%h ep=%b expected %h/0", button_word, event_pending, 32'h0100_0001);
        end
        key_raw = 4'hF;
        tick(15);
        tests_run++;
        if (button_word !== 32'h0100_0000) begin
            tests_failed++;
            $display("FAIL release_key0: bw=%h expected %h", button_word, 32'h0100_0000);
        end
        key_raw = 4'hE;
        tick(15);
        tests_run++;
        if (button_word !== 32'h0201_0001 || event_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL repress_ack_held: bw=%h ep=%b expected %h/1", button_word, event_pending, 32'h0201_0001);
        end
        ack_word = 32'h0;
        tick(2);
        $display("[TB] ack key0 bw=%h", button_word);
    endtask

    task automatic test_same_cycle();
        // The ack edge lands on the earliest allowed press edge; either way the flag must end set.
        key_raw = 4'hA;
        tick(9);
        ack_word = 32'h4;
        tick(5);
        tests_run++;
        if (button_word !== 32'h0305_0005) begin
            tests_failed++;
            $display("FAIL press_ack_same: bw=%h expected %h", button_word, 32'h0305_0005);
        end
        key_raw = 4'hF;
        tick(15);
        ack_word = 32'h0;
        tests_run++;
        if (button_word !== 32'h0305_0000) begin
            tests_failed++;
            $display("FAIL release_all: bw=%h expected %h", button_word, 32'h0305_0000);
        end
        key_raw = 4'h6;
        tick(15);
        tests_run++;
        if (button_word !== 32'h040D_0009 || event_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL dual_press: bw=%h ep=%b expected %h/1", button_word, event_pending, 32'h040D_0009);
        end
        $display("[TB] same-cycle bw=%h", button_word);
    endtask

    task automatic test_switches();
        key_raw = 4'hF;
        tick(15);
        sw_raw = 18'h2A5A5;
        tick(9);
        tests_run++;
        if (switch_word !== 32'h0) begin
            tests_failed++;
            $display("FAIL switch_early: sw=%h expected %h", switch_word, 32'h0);
        end
        tick(2);
        tests_run++;
        if (switch_word !== 32'h0002_A5A5) begin
            tests_failed++;
            $display("FAIL switch_value: sw=%h expected %h", switch_word, 32'h0002_A5A5);
        end
        ack_word = 32'hFFFF_FFF0;
        tick(2);
        tests_run++;
        if (button_word !== 32'h040D_0000) begin
            tests_failed++;
            $display("FAIL ack_high_bits: bw=%h expected %h", button_word, 32'h040D_0000);
        end
        ack_word = 32'h0;
        tick(2);
        $display("[TB] switches sw=%h", switch_word);
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < 256; i++) begin
            key_raw = 4'hE;
            tick(12);
            key_raw = 4'hF;
            tick(12);
            if (i == 254) begin
                tests_run++;
                if (button_word !== 32'hFF01_0000) begin
                    tests_failed++;
                    $display("FAIL count_255: bw=%h expected %h", button_word, 32'hFF01_0000);
                end
            end
        end
        tests_run++;
        if (button_word !== 32'h0001_0000) begin
            tests_failed++;
            $display("FAIL count_wrap: bw=%h expected %h", button_word, 32'h0001_0000);
        end
        $display("[TB] wrap bw=%h", button_word);
    endtask

    task automatic test_reset_mid_pending();
        key_raw = 4'hD;
        tick(5);
        reset = 1'b1;
        #1;
        tests_run++;
        if (button_word !== 32'h0 || switch_word !== 32'h0 || event_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: bw=%h sw=%h ep=%b expected 0/0/0", button_word, switch_word, event_pending);
        end
        tick(3);
        reset = 1'b0;
        tick(9);
        tests_run++;
        if (button_word !== 32'h0) begin
            tests_failed++;
            $display("FAIL pending_discard: bw=%h expected %h", button_word, 32'h0);
        end
        tick(2);
        tests_run++;
        if (button_word !== 32'h0102_0002 || switch_word !== 32'h0002_A5A5) begin
            tests_failed++;
            $display("FAIL after_reset: bw=%h sw=%h expected %h/%h", button_word, switch_word,
                     32'h0102_0002, 32'h0002_A5A5);
        end
        $display("[TB] reset mid-pending bw=%h", button_word);
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_ack();
        test_same_cycle();
        test_switches();
        test_wrap();
        test_reset_mid_pending();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
